// File: rtl/dmem_stage_mc.sv
// -----------------------------------------------------------------------------
// dmem_stage_mc -- multi-cycle data-memory (MEM) stage for the pipelined core.
//
// Holds a word-addressed register array and services one load or store at a
// time. An accepted access completes LATENCY cycles later with a one-cycle
// done pulse. stall freezes the pipeline while the access is in flight.
// Halt and error conditions park the block in a sticky HALT state, so the
// memory can be dumped after a halt. Only rst leaves the HALT state.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high. Clears the FSM, the
//                   outputs and every memory word.
//   isHalt     in   halt request from the pipeline
//   mem_read   in   load request (level, held while stall=1)
//   mem_write  in   store request (level, held while stall=1)
//   addr       in   byte address. Word index = addr[BO+IW-1:BO].
//   wr_data    in   store data
//   rd_data    out  load data. Valid while done=1, otherwise 0.
//   stall      out  pipeline freeze (combinational)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle error pulse, coincident with done
//   halted     out  sticky halt indicator
//
// Optional feature macro: ALIGN_CHECK_EN
//   Defined   : an access with nonzero low byte-offset bits completes with
//               err=1. No write is performed and rd_data is 0.
//   Undefined : the offset bits are ignored.
// -----------------------------------------------------------------------------
module dmem_stage_mc #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isHalt,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              halted
);

    localparam int BO = $clog2(DATA_W / 8);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]     LAT_M1   = CW'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << BO) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              op_rd_reg, op_rd_next;
    logic              op_wr_reg, op_wr_next;
    logic              mis_reg, mis_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [DATA_W-1:0] wd_reg, wd_next;
    logic              halt_pend_reg, halt_pend_next;
    logic              done_reg, err_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic              req, idle_like, halt_go, accept, fire;
    logic              mis_live;
    logic [IW-1:0]     idx_live;
    logic              sel_rd, sel_wr, sel_mis, bad, we, ld;
    logic [IW-1:0]     sel_idx;
    logic [DATA_W-1:0] sel_wd;
    logic              unused_addr;

    assign idx_live    = addr[BO+IW-1:BO];
    assign unused_addr = ^addr;

`ifdef ALIGN_CHECK_EN
    assign mis_live = |(addr & LOW_MASK);
`else
    assign mis_live = 1'b0 & (|(addr & LOW_MASK));
`endif

    assign req       = mem_read | mem_write;
    assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE);
    // A pending halt or an error reported in the DONE cycle blocks a new
    // accept, so stall must not freeze the pipeline for a request that will
    // never be serviced.
    assign halt_go   = isHalt | halt_pend_reg | err_reg;
    assign accept    = idle_like & req & ~halt_go;
    assign stall     = accept | (state_reg == S_BUSY);

    // When LATENCY==1 the access fires on the accept edge itself. In that
    // case the live inputs feed the array instead of the latched copies.
    assign sel_rd  = (state_reg == S_BUSY) ? op_rd_reg : mem_read;
    assign sel_wr  = (state_reg == S_BUSY) ? op_wr_reg : mem_write;
    assign sel_mis = (state_reg == S_BUSY) ? mis_reg   : mis_live;
    assign sel_idx = (state_reg == S_BUSY) ? idx_reg   : idx_live;
    assign sel_wd  = (state_reg == S_BUSY) ? wd_reg    : wr_data;

    assign bad = (sel_rd & sel_wr) | sel_mis;
    assign we  = fire & sel_wr & ~bad;
    assign ld  = fire & sel_rd & ~bad;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_rd_next     = op_rd_reg;
        op_wr_next     = op_wr_reg;
        mis_next       = mis_reg;
        idx_next       = idx_reg;
        wd_next        = wd_reg;
        halt_pend_next = halt_pend_reg;
        fire           = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (halt_go) begin
                    state_next     = S_HALT;
                    halt_pend_next = 1'b0;
                end else if (req) begin
                    op_rd_next = mem_read;
                    op_wr_next = mem_write;
                    mis_next   = mis_live;
                    idx_next   = idx_live;
                    wd_next    = wr_data;
                    cnt_next   = LAT_M1;
                    if (LAT_M1 == '0) begin
                        fire       = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_BUSY;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_next = cnt_reg - CW'(1);
                if (isHalt) begin
                    halt_pend_next = 1'b1;
                end
                // The access lands on the edge where the count reaches zero.
                // This puts done exactly LATENCY cycles after the accept.
                if (cnt_reg <= CW'(1)) begin
                    fire       = 1'b1;
                    cnt_next   = '0;
                    state_next = S_DONE;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            op_rd_reg     <= 1'b0;
            op_wr_reg     <= 1'b0;
            mis_reg       <= 1'b0;
            idx_reg       <= '0;
            wd_reg        <= '0;
            halt_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            rd_data_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_rd_reg     <= op_rd_next;
            op_wr_reg     <= op_wr_next;
            mis_reg       <= mis_next;
            idx_reg       <= idx_next;
            wd_reg        <= wd_next;
            halt_pend_reg <= halt_pend_next;
            done_reg      <= fire;
            err_reg       <= fire & bad;
            rd_data_reg   <= ld ? mem_reg[sel_idx] : '0;
            if (we) begin
                mem_reg[sel_idx] <= sel_wd;
            end
        end
    end

    assign rd_data = rd_data_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign halted  = (state_reg == S_HALT);

endmodule
